// File: rtl/i2s_poly_synth_pkg.sv
// Shared types for the I2S polyphonic wavetable synth.
// The keycode to note map covers eight HID keys: A S D F H J K L.
package i2s_synth_pkg;

   localparam int VOICE_NOTE_W = 3;
   localparam int VOICE_ADDR_W = 8;

   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_D = 8'h07;
   localparam logic [7:0] KEY_F = 8'h09;
   localparam logic [7:0] KEY_H = 8'h0B;
   localparam logic [7:0] KEY_J = 8'h0D;
   localparam logic [7:0] KEY_K = 8'h0E;
   localparam logic [7:0] KEY_L = 8'h0F;

   typedef struct packed {
      logic                    active;
      logic [VOICE_NOTE_W-1:0] note;
      logic [VOICE_ADDR_W-1:0] phase;
   } voice_t;

   typedef enum logic [1:0] {IDLE, ISSUE, ACC, DONE} seq_state_e;

   // Returns {valid, note}; valid is 0 for any key outside the map.
   function automatic logic [VOICE_NOTE_W:0] key_to_note(input logic [7:0] key);
      case (key)
         KEY_A:   key_to_note = {1'b1, 3'd0};
         KEY_S:   key_to_note = {1'b1, 3'd1};
         KEY_D:   key_to_note = {1'b1, 3'd2};
         KEY_F:   key_to_note = {1'b1, 3'd3};
         KEY_H:   key_to_note = {1'b1, 3'd4};
         KEY_J:   key_to_note = {1'b1, 3'd5};
         KEY_K:   key_to_note = {1'b1, 3'd6};
         KEY_L:   key_to_note = {1'b1, 3'd7};
         default: key_to_note = '0;
      endcase
   endfunction

endpackage

// File: rtl/i2s_poly_synth_if.sv
// Codec word-select / serial data and sample-ROM port of the synth.
// master = synth side, slave = codec + ROM side.
interface i2s_poly_synth_if #(
   parameter int SAMPLE_W   = 16,
   parameter int ROM_ADDR_W = 11
);
   logic                       I2S_LRCLK;
   logic                       I2S_DIN;
   logic [ROM_ADDR_W-1:0]      rom_addr;
   logic signed [SAMPLE_W-1:0] rom_q;

   modport master (input I2S_LRCLK, input rom_q, output I2S_DIN, output rom_addr);
   modport slave  (output I2S_LRCLK, output rom_q, input I2S_DIN, input rom_addr);
endinterface

// File: rtl/i2s_poly_synth_tx_serializer.sv
// I2S transmitter: LRCLK edge detect, armed flag and MSB-first shift register.
// The mix is captured once per frame so left and right carry the same word.
module i2s_tx_serializer #(
   parameter int SAMPLE_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       lrclk,
   input  logic signed [SAMPLE_W-1:0] mix,
   output logic                       lr_edge,
   output logic                       lr_fall,
   output logic                       din
);
   logic                lr_q;
   logic                armed;
   logic [SAMPLE_W-1:0] shreg;
   logic [SAMPLE_W-1:0] hold;

   assign lr_edge = armed & (lr_q != lrclk);
   assign lr_fall = lr_edge & ~lrclk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lr_q  <= 1'b0;
         armed <= 1'b0;
         shreg <= '0;
         hold  <= '0;
         din   <= 1'b0;
      end else begin
         lr_q  <= lrclk;
         armed <= 1'b1;
         din   <= shreg[SAMPLE_W-1];
         // right word reuses the value captured at the left edge
         if (lr_fall) begin
            hold  <= mix;
            shreg <= mix;
         end else if (lr_edge) begin
            shreg <= hold;
         end else begin
            shreg <= {shreg[SAMPLE_W-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/i2s_poly_synth.sv
// Polyphonic wavetable player: keycode voices, ROM fetch sequencer, mono mix to I2S.
// Build option SATURATE_MIX_EN: clamp the voice sum instead of averaging it.
//
// state | meaning
// IDLE  | waiting for a falling LRCLK edge
// ISSUE | one ROM address per clk, voice 0..NUM_VOICES-1
// ACC   | accumulate the last voice's sample
// DONE  | scaled sum written to the mix register
module i2s_poly_synth
   import i2s_synth_pkg::*;
#(
   parameter int NUM_VOICES  = 4,
   parameter int SAMPLE_W    = 16,
   parameter int NOTE_ADDR_W = VOICE_ADDR_W,
   parameter int NOTE_W      = VOICE_NOTE_W
) (
   input  logic                    I2S_SCLK,
   input  logic                    Reset_n,
   input  logic [8*NUM_VOICES-1:0] keycode,
   output logic [NUM_VOICES-1:0]   voice_active,
   i2s_poly_synth_if.master        bus
);
   localparam int LOG_N      = $clog2(NUM_VOICES);
   localparam int ACC_W      = SAMPLE_W + LOG_N;
   localparam int IDX_W      = (LOG_N > 0) ? LOG_N : 1;
   localparam int ROM_ADDR_W = NOTE_W + NOTE_ADDR_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   voice_t                    voice   [NUM_VOICES];
   logic [VOICE_NOTE_W:0]     key_map [NUM_VOICES];
   seq_state_e                state;
   logic [IDX_W-1:0]          idx;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   q_ext;
   logic                      acc_vld;
   logic                      issue_act;
   logic signed [SAMPLE_W-1:0] mix;
   logic signed [SAMPLE_W-1:0] mix_next;
   logic                      lr_edge;
   logic                      lr_fall;
   logic                      din;
   logic                      start;

   always_comb begin
      voice_active = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         key_map[v]      = key_to_note(keycode[8*v +: 8]);
         voice_active[v] = voice[v].active;
      end
   end

   always_ff @(posedge I2S_SCLK or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int v = 0; v < NUM_VOICES; v++) voice[v] <= '0;
      end else if (lr_fall) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (!key_map[v][VOICE_NOTE_W]) begin
               voice[v].active <= 1'b0;
               voice[v].phase  <= '0;
            end else if (!voice[v].active || key_map[v][VOICE_NOTE_W-1:0] != voice[v].note) begin
               voice[v].active <= 1'b1;
               voice[v].note   <= key_map[v][VOICE_NOTE_W-1:0];
               voice[v].phase  <= '0;
            end else begin
               voice[v].phase  <= voice[v].phase + 1'b1;
            end
         end
      end
   end

   // Any edge mid-sequence restarts it; the old mix stays until DONE.
   assign start = lr_fall | (lr_edge & (state != IDLE));
   assign q_ext = ACC_W'(bus.rom_q);

`ifdef SATURATE_MIX_EN
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (SAMPLE_W-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

   always_comb begin
      mix_next = acc[SAMPLE_W-1:0];
      if (acc > SAT_HI)      mix_next = SAT_HI[SAMPLE_W-1:0];
      else if (acc < SAT_LO) mix_next = SAT_LO[SAMPLE_W-1:0];
   end
`else
   always_comb mix_next = SAMPLE_W'(acc >>> LOG_N);
`endif

   always_ff @(posedge I2S_SCLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state        <= IDLE;
         idx          <= '0;
         acc          <= '0;
         acc_vld      <= 1'b0;
         issue_act    <= 1'b0;
         bus.rom_addr <= '0;
         mix          <= '0;
      end else begin
         acc_vld <= 1'b0;
         if (acc_vld && issue_act) acc <= acc + q_ext;
         if (start) begin
            state <= ISSUE;
            idx   <= '0;
            acc   <= '0;
         end else begin
            case (state)
               ISSUE: begin
                  bus.rom_addr <= ROM_ADDR_W'({voice[idx].note, voice[idx].phase});
                  issue_act    <= voice[idx].active;
                  acc_vld      <= 1'b1;
                  if (idx == LAST_IDX) state <= ACC;
                  else                 idx   <= idx + 1'b1;
               end
               ACC:  state <= DONE;
               DONE: begin
                  mix   <= mix_next;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   i2s_tx_serializer #(.SAMPLE_W(SAMPLE_W)) u_tx (
      .clk     (I2S_SCLK),
      .rst_n   (Reset_n),
      .lrclk   (bus.I2S_LRCLK),
      .mix     (mix),
      .lr_edge (lr_edge),
      .lr_fall (lr_fall),
      .din     (din)
   );

   assign bus.I2S_DIN = din;

endmodule

// File: tb/tb_i2s_poly_synth.sv
// Bench for i2s_poly_synth: 64-SCLK frames, random keys and ROM, frame-level reference model.
module tb_i2s_poly_synth;
   import i2s_synth_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] keycode = '0;
   logic [3:0]  voice_active;

   i2s_poly_synth_if #(.SAMPLE_W(16), .ROM_ADDR_W(11)) bus ();

   i2s_poly_synth dut (
      .I2S_SCLK     (clk),
      .Reset_n      (rst_n),
      .keycode      (keycode),
      .voice_active (voice_active),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   logic signed [15:0] rom [2048];
   assign bus.rom_q = rom[bus.rom_addr];

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0] key_tab [8] = '{8'h04, 8'h16, 8'h07, 8'h09, 8'h0B, 8'h0D, 8'h0E, 8'h0F};
   int          m_act [4];
   int          m_note [4];
   int          m_phase [4];
   int          model_next;
   logic [15:0] exp_word;

   logic        lslot [32];
   logic        rslot [32];
   logic [10:0] addr_s [8];
   logic [15:0] lw, rw;
   logic        tail;

`ifdef SATURATE_MIX_EN
   localparam logic [15:0] FS_POS = 16'h7FFF;
`else
   localparam logic [15:0] FS_POS = 16'h7000;
`endif

   function automatic int note_of(input logic [7:0] k);
      for (int i = 0; i < 8; i++) if (key_tab[i] == k) return i;
      return -1;
   endfunction

   function automatic int scale(input int s);
`ifdef SATURATE_MIX_EN
      if (s > 32767) return 32767;
      if (s < -32768) return -32768;
      return s;
`else
      if (s >= 0) return s / 4;
      return -((-s + 3) / 4);
`endif
   endfunction

   function automatic logic [3:0] model_act();
      logic [3:0] a;
      for (int v = 0; v < 4; v++) a[v] = (m_act[v] != 0);
      return a;
   endfunction

   function automatic logic [10:0] model_addr(input int v);
      return 11'(m_note[v] * 256 + m_phase[v]);
   endfunction

   task automatic model_reset();
      for (int v = 0; v < 4; v++) begin
         m_act[v] = 0; m_note[v] = 0; m_phase[v] = 0;
      end
      model_next = 0;
   endtask

   task automatic model_frame();
      int s;
      int n;
      s = 0;
      for (int v = 0; v < 4; v++) begin
         n = note_of(keycode[8*v +: 8]);
         if (n < 0) begin
            m_act[v] = 0; m_phase[v] = 0;
         end else if (m_act[v] == 0 || n != m_note[v]) begin
            m_act[v] = 1; m_note[v] = n; m_phase[v] = 0;
         end else begin
            m_phase[v] = (m_phase[v] + 1) % 256;
         end
      end
      for (int v = 0; v < 4; v++)
         if (m_act[v] != 0) s += int'(rom[m_note[v] * 256 + m_phase[v]]);
      model_next = scale(s);
   endtask

   task automatic init_rom_random();
      for (int i = 0; i < 2048; i++) rom[i] = 16'($urandom);
   endtask

   function automatic logic [7:0] rand_key();
      int r;
      r = $urandom_range(0, 9);
      if (r < 8) return key_tab[r];
      if (r == 8) return 8'h2C;
      return 8'h00;
   endfunction

   // One frame starting at a negedge: left half (optionally cut short), then 32-clk right half.
   task automatic run_frame(input bit short_left);
      exp_word = 16'(model_next);
      model_frame();
      bus.I2S_LRCLK = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         lslot[i] = bus.I2S_DIN;
         if (i < 8) addr_s[i] = bus.rom_addr;
         if (short_left && i == 2) break;
      end
      bus.I2S_LRCLK = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         rslot[i] = bus.I2S_DIN;
      end
      for (int i = 0; i < 16; i++) begin
         lw[15-i] = lslot[1+i];
         rw[15-i] = rslot[1+i];
      end
      tail = lslot[0] | rslot[0];
      for (int i = 17; i < 32; i++) tail = tail | lslot[i] | rslot[i];
   endtask

   task automatic test_reset();
      logic bad;
      keycode = {24'h0, KEY_A};
      bus.I2S_LRCLK = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (bus.I2S_DIN !== 1'b0 || voice_active !== 4'b0 || bus.rom_addr !== 11'h0) begin
         tests_failed++;
         $display("FAIL reset_state: din=%b act=%b addr=%h, required 0/0/0", bus.I2S_DIN, voice_active, bus.rom_addr);
      end
      rst_n = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      run_frame(1'b0);
      run_frame(1'b0);
      bus.I2S_LRCLK = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         if (i % 12 == 11) bus.I2S_LRCLK = ~bus.I2S_LRCLK;
         if (bus.I2S_DIN !== 1'b0 || voice_active !== 4'b0 || bus.rom_addr !== 11'h0) bad = 1'b1;
      end
      tests_run++;
      if (bad !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_hold: outputs nonzero during reset, required all 0");
      end
      rst_n = 1'b1;
      model_reset();
      bus.I2S_LRCLK = 1'b1;
      repeat (3) @(negedge clk);
      run_frame(1'b0);
      tests_run++;
      if (lw !== 16'h0 || rw !== 16'h0 || tail !== 1'b0) begin
         tests_failed++;
         $display("FAIL first_word: got L=%h R=%h tail=%b, required 0000/0000/0", lw, rw, tail);
      end
      tests_run++;
      if (voice_active !== model_act()) begin
         tests_failed++;
         $display("FAIL reset_active: got %b, required %b", voice_active, model_act());
      end
   endtask

   task automatic test_single_voice();
      init_rom_random();
      for (int p = 0; p < 256; p++) rom[p] = 16'(p * 256);
      keycode = {24'h0, KEY_A};
      for (int f = 0; f < 260; f++) begin
         run_frame(1'b0);
         tests_run++;
         if (lw !== exp_word || rw !== exp_word) begin
            tests_failed++;
            $display("FAIL single_word f=%0d: got L=%h R=%h, required %h", f, lw, rw, exp_word);
         end
         tests_run++;
         if (addr_s[1] !== model_addr(0)) begin
            tests_failed++;
            $display("FAIL single_addr f=%0d: got %h, required %h", f, addr_s[1], model_addr(0));
         end
      end
   endtask

   task automatic test_note_change();
      keycode[7:0] = KEY_S;
      run_frame(1'b0);
      tests_run++;
      if (addr_s[1] !== 11'h100 || voice_active[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL note_change: got addr=%h act=%b, required 100/1", addr_s[1], voice_active[0]);
      end
      tests_run++;
      if (lw !== exp_word) begin
         tests_failed++;
         $display("FAIL note_change_word: got %h, required %h", lw, exp_word);
      end
      run_frame(1'b0);
      tests_run++;
      if (addr_s[1] !== 11'h101) begin
         tests_failed++;
         $display("FAIL note_advance: got %h, required 101", addr_s[1]);
      end
   endtask

   task automatic test_full_scale();
      keycode = {KEY_F, KEY_D, KEY_S, KEY_A};
      for (int i = 0; i < 1024; i++) rom[i] = 16'sh7000;
      run_frame(1'b0);
      run_frame(1'b0);
      tests_run++;
      if (lw !== FS_POS || rw !== FS_POS) begin
         tests_failed++;
         $display("FAIL full_pos: got L=%h R=%h, required %h", lw, rw, FS_POS);
      end
      for (int i = 0; i < 1024; i++) rom[i] = 16'sh8000;
      run_frame(1'b0);
      run_frame(1'b0);
      tests_run++;
      if (lw !== 16'h8000 || rw !== 16'h8000) begin
         tests_failed++;
         $display("FAIL full_neg: got L=%h R=%h, required 8000", lw, rw);
      end
   endtask

   task automatic test_unmapped();
      init_rom_random();
      for (int f = 0; f < 3; f++) begin
         keycode = {key_tab[$urandom_range(0, 7)], 8'h2C, key_tab[$urandom_range(0, 7)], key_tab[$urandom_range(0, 7)]};
         run_frame(1'b0);
         tests_run++;
         if (voice_active[2] !== 1'b0 || voice_active !== model_act()) begin
            tests_failed++;
            $display("FAIL unmapped_act: got %b, required %b", voice_active, model_act());
         end
         for (int v = 0; v < 4; v++) begin
            tests_run++;
            if (addr_s[1+v] !== model_addr(v)) begin
               tests_failed++;
               $display("FAIL unmapped_addr v=%0d: got %h, required %h", v, addr_s[1+v], model_addr(v));
            end
         end
         tests_run++;
         if (lw !== exp_word || rw !== exp_word) begin
            tests_failed++;
            $display("FAIL unmapped_word: got L=%h R=%h, required %h", lw, rw, exp_word);
         end
      end
   endtask

   task automatic test_bit_timing();
      for (int i = 0; i < 2048; i++) rom[i] = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
      keycode = {KEY_L, KEY_K, KEY_J, KEY_H};
      run_frame(1'b0);
      run_frame(1'b0);
      tests_run++;
      if (lslot[0] !== 1'b0 || lslot[1] !== 1'b1 || rslot[1] !== 1'b1) begin
         tests_failed++;
         $display("FAIL msb_delay: got slot0=%b Lmsb=%b Rmsb=%b, required 0/1/1", lslot[0], lslot[1], rslot[1]);
      end
      tests_run++;
      if (tail !== 1'b0 || lw !== rw || lw !== exp_word) begin
         tests_failed++;
         $display("FAIL word_frame: got L=%h R=%h tail=%b, required %h/%h/0", lw, rw, tail, exp_word, exp_word);
      end
      keycode = {KEY_A, KEY_S, KEY_D, KEY_F};
      run_frame(1'b1);
      tests_run++;
      if (rw !== exp_word) begin
         tests_failed++;
         $display("FAIL extra_edge_r: got %h, required %h", rw, exp_word);
      end
      run_frame(1'b0);
      tests_run++;
      if (lw !== exp_word || rw !== exp_word || tail !== 1'b0) begin
         tests_failed++;
         $display("FAIL after_extra_edge: got L=%h R=%h tail=%b, required %h", lw, rw, tail, exp_word);
      end
   endtask

   task automatic test_random();
      init_rom_random();
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 1) == 0)
            for (int v = 0; v < 4; v++) keycode[8*v +: 8] = rand_key();
         run_frame(1'b0);
         tests_run++;
         if (lw !== exp_word || rw !== exp_word) begin
            tests_failed++;
            $display("FAIL random_word f=%0d: got L=%h R=%h, required %h", f, lw, rw, exp_word);
         end
         tests_run++;
         if (voice_active !== model_act()) begin
            tests_failed++;
            $display("FAIL random_act f=%0d: got %b, required %b", f, voice_active, model_act());
         end
         for (int v = 0; v < 4; v++) begin
            tests_run++;
            if (addr_s[1+v] !== model_addr(v)) begin
               tests_failed++;
               $display("FAIL random_addr f=%0d v=%0d: got %h, required %h", f, v, addr_s[1+v], model_addr(v));
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.I2S_LRCLK = 1'b1;
      init_rom_random();
      model_reset();
      test_reset();
      test_single_voice();
      test_note_change();
      test_full_scale();
      test_unmapped();
      test_bit_timing();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
